alu_operand_sequencer: RTL

Next-generation operand entry front end for the ALU board top. It takes raw board pushbuttons and switches and produces two signed operands and an opcode. It replaces per-field "set" buttons with one debounced ENTER button and one BACK button, driven by an entry state machine. The completed operand set is delivered to the ALU/result stage over a valid/ready handshake, and the current entry stage is exported for the LEDs.

---
 rtl/alu_if_pkg.sv | 21 ++
 rtl/btn_debouncer.sv | 74 +++++++
 rtl/alu_operand_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_if_pkg
// Description : Shared widths and entry-stage encoding for the ALU operand
//               entry front end.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_if_pkg;

  // Default operand and opcode widths
  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  // Entry stage encoding, also exported on o_state for the LEDs
  localparam logic [1:0] ST_OP1   = 2'd0;
  localparam logic [1:0] ST_OP2   = 2'd1;
  localparam logic [1:0] ST_OPR   = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : btn_debouncer
// Description : Synchronises a raw bouncing pushbutton, debounces it with a
//               stability counter and emits a one-cycle press pulse on each
//               accepted 0->1 transition.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer #(
  parameter int DB_CYCLES = 1000000,
  parameter int NB_DB_CNT = 20
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam logic [NB_DB_CNT-1:0] C_CNT_LAST = NB_DB_CNT'(DB_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_level;
  logic [NB_DB_CNT-1:0] r_cnt;
  logic                 r_level_d1;
  logic                 r_level_d2;
  logic                 r_press;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a level change only after DB_CYCLES consecutive differing cycles
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == C_CNT_LAST) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Rising-edge detect on a delayed copy of the level; the two delay stages
  // place the pulse exactly DB_CYCLES+3 cycles after the first raw sample
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_level_d1 <= 1'b0;
      r_level_d2 <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_level_d1 <= r_level;
      r_level_d2 <= r_level_d1;
      r_press    <= r_level_d1 & ~r_level_d2;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_sequencer
// Description : Operand entry front end. Two debounced buttons (ENTER, BACK)
//               step an entry state machine that captures two signed operands
//               and an opcode from the switches, then offers the completed set
//               downstream over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer
  import alu_if_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_OP     = NB_OP_DEF,
  parameter int DB_CYCLES = 1000000,
  parameter int NB_DB_CNT = 20
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_switches,
  input  logic               i_btn_enter,
  input  logic               i_btn_back,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_operand1,
  output logic [NB_DATA-1:0] o_operand2,
  output logic [NB_OP-1:0]   o_operator,
  output logic               o_valid,
  output logic [1:0]         o_state
);

  logic w_enter;
  logic w_back;
  logic w_unused_enter_level;
  logic w_unused_back_level;

  logic [1:0]         r_state;
  logic [NB_DATA-1:0] r_operand1;
  logic [NB_DATA-1:0] r_operand2;
  logic [NB_OP-1:0]   r_operator;
  logic               r_valid;

  btn_debouncer #(
    .DB_CYCLES (DB_CYCLES),
    .NB_DB_CNT (NB_DB_CNT)
  ) u_db_enter (
    .clk     (clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_enter),
    .o_level (w_unused_enter_level),
    .o_press (w_enter)
  );

  btn_debouncer #(
    .DB_CYCLES (DB_CYCLES),
    .NB_DB_CNT (NB_DB_CNT)
  ) u_db_back (
    .clk     (clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_back),
    .o_level (w_unused_back_level),
    .o_press (w_back)
  );

  // Entry state machine; each captured field updates on the edge the stage
  // advances, and BACK takes priority over ENTER where it has an effect
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state    <= ST_OP1;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_operator <= '0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_OP1: begin
          if (w_enter) begin
            r_operand1 <= i_switches;
            r_state    <= ST_OP2;
          end
        end
        ST_OP2: begin
          if (w_back) begin
            r_state <= ST_OP1;
          end else if (w_enter) begin
            r_operand2 <= i_switches;
            r_state    <= ST_OPR;
          end
        end
        ST_OPR: begin
          if (w_back) begin
            r_state <= ST_OP2;
          end else if (w_enter) begin
            r_operator <= i_switches[NB_OP-1:0];
            r_state    <= ST_ISSUE;
            r_valid    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // Buttons are ignored here; only the handshake leaves this stage
          if (r_valid && i_ready) begin
            r_state <= ST_OP1;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_OP1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_operand1 = r_operand1;
  assign o_operand2 = r_operand2;
  assign o_operator = r_operator;
  assign o_valid    = r_valid;
  assign o_state    = r_state;

endmodule
`default_nettype wire
